pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the five-stage MIPS pipeline. It watches the IF/ID, ID/EX and EX/MEM stage registers and drives their enable and flush controls. It also drives the PC enable. It resolves three hazard classes:
- load-use hazards
- taken branch/jump redirects resolved in EX/MEM
- multi-cycle data-memory waits

It keeps a saturating stall-cycle counter for performance debug.

Parameters:
REG_ADDR_W, 5, register-file address width
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3; 2 when MEM→EX forwarding is absent)
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock; all state updates on falling edge, matching the stage registers
rst  in  1  synchronous active-low reset
idex_memtoreg  in  1  ID/EX holds a load
idex_rt  in  REG_ADDR_W  load destination in ID/EX
ifid_rs  in  REG_ADDR_W  rs of instruction in IF/ID
ifid_rt  in  REG_ADDR_W  rt of instruction in IF/ID
ifid_uses_rt  in  1  IF/ID instruction reads rt
redirect_exmem  in  1  taken branch or jump/jr in EX/MEM
mem_access_exmem  in  1  EX/MEM holds a load or store
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX clear (bubble)
exmem_en  out  1  EX/MEM enable
exmem_flush  out  1  EX/MEM clear
memwb_flush  out  1  MEM/WB clear
ctrl_state  out  2  0=RUN, 1=LU_STALL, 2=MEM_WAIT
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating

Behaviour:
- Reset (rst=0 at a falling edge):
  - state←RUN; lu_cnt←0; stall_cnt←0.
  - While rst=0, outputs are pc_en=1, all *_en=1, all *_flush=0, ctrl_state=0.
  - Stage registers self-clear on their own reset.
- Outputs are a combinational decode of the registered state and the current inputs. Same-cycle response, zero latency.
- Terms:
  - lu = idex_memtoreg & (idex_rt≠0) & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).
  - mw = mem_access_exmem & ~mem_ready.
- Priority (highest first): mw > redirect_exmem > LU_STALL/lu.
- mw asserted, any state:
  - Outputs: pc_en=0, ifid_en=0, idex_en=0, exmem_en=0, memwb_flush=1, other flushes 0.
  - Next state MEM_WAIT; lu_cnt frozen.
  - A redirect coincident with mw is deferred: the inputs stay held, so the redirect is honoured in the first cycle mw clears.
- MEM_WAIT with mw=0: normal decode of RUN rules this cycle. Next state is LU_STALL if lu_cnt≠0, else RUN.
- redirect_exmem (mw=0):
  - Outputs: ifid_flush=1, idex_flush=1, exmem_flush=1, pc_en=1, all en=1.
  - lu_cnt←0; next state RUN. This aborts any load-use stall, because the stalled instruction is wrong-path.
- RUN, lu=1 (no redirect, no mw):
  - Outputs: pc_en=0, ifid_en=0, idex_flush=1.
  - If LOAD_USE_BUBBLES>1: lu_cnt←LOAD_USE_BUBBLES-1, next state LU_STALL. Otherwise stay RUN.
- LU_STALL (no redirect, no mw):
  - Outputs: same as lu=1 in RUN.
  - lu_cnt decrements; when it reaches 0, next state RUN.
  - lu is ignored in this state.
- stall_cnt: increments at each falling edge where pc_en=0 and rst=1. Holds at 2^CNT_W-1.
- Register 0 never triggers a hazard.
- ctrl_state=3 is unreachable. If it is ever reached, it decodes as RUN and returns to RUN next edge.

Decomposition:
- Shared package `pipeline_pkg`:
  - state enum hz_state_e {HZ_RUN, HZ_LU_STALL, HZ_MEM_WAIT}
  - REG_ADDR_W default
  - REG_ZERO constant
- One natural sub-module: `load_use_detect`, the combinational lu term. The remainder (FSM, lu_cnt, stall_cnt, output decode) stays in the top.

Test Plan:
- Load-use, default params: lw r8 in ID/EX (idex_memtoreg=1, idex_rt=8), add r9,r8,r1 in IF/ID (ifid_rs=8) → one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; stall_cnt=1.
- LOAD_USE_BUBBLES=2, same stimulus → two consecutive stall cycles, ctrl_state 0→1→0, stall_cnt=2. Repeat with idex_rt=0 → no stall.
- Redirect: redirect_exmem=1 for one cycle while in LU_STALL → ifid_flush=idex_flush=exmem_flush=1, pc_en=1, state RUN next edge, lu_cnt=0.
- Memory wait: mem_access_exmem=1, mem_ready=0 for 3 cycles then 1 → pc_en/ifid_en/idex_en/exmem_en=0 and memwb_flush=1 for exactly 3 cycles, ctrl_state=2, stall_cnt+=3; combine with a pending LU_STALL (lu_cnt=1) → resumes LU_STALL after the wait.
- mw and redirect asserted together for 2 cycles, then mem_ready=1 → no flush during wait; flushes asserted in the first cycle after release.
- Reset mid-LU_STALL and mid-MEM_WAIT (rst=0 one edge) → state RUN, stall_cnt=0, outputs at reset values. CNT_W=4 run of 20 stall cycles → stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO       = 0;
  localparam int unsigned LU_CNT_W       = 2;
  localparam int unsigned CTRL_W         = 8;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } hz_state_e;

  // Stage-register control bundle, MSB first.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN      = CTRL_W'(8'b1101_0100);
  localparam hz_ctrl_t CTRL_LU       = CTRL_W'(8'b0001_1100);
  localparam hz_ctrl_t CTRL_MEM_WAIT = CTRL_W'(8'b0000_0001);
  localparam hz_ctrl_t CTRL_REDIRECT = CTRL_W'(8'b1111_1110);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term between ID/EX load and IF/ID consumer.
module load_use_detect
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  idex_memtoreg,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rt,
  output logic                  lu_c
);

  logic dst_nonzero;
  logic rs_match;
  logic rt_match;

  // r0 is hardwired, so a load targeting it can never create a dependency.
  assign dst_nonzero = (idex_rt != REG_ADDR_W'(REG_ZERO));
  assign rs_match    = (idex_rt == ifid_rs);
  assign rt_match    = ifid_uses_rt & (idex_rt == ifid_rt);
  assign lu_c        = idex_memtoreg & dst_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline; state advances on the
// falling clock edge so it lines up with the stage registers it steers.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_W       = REG_ADDR_W_DEF,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_memtoreg,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rt,
  input  logic                  redirect_exmem,
  input  logic                  mem_access_exmem,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cnt
);

  hz_state_e           state_q, state_d;
  logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  hz_ctrl_t            ctrl;
  logic                lu;
  logic                mw;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .idex_memtoreg (idex_memtoreg),
    .idex_rt       (idex_rt),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .lu_c          (lu)
  );

  assign mw = mem_access_exmem & ~mem_ready;

  // Next-state and output decode; priority is memory wait, redirect, load-use.
  always_comb begin
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    ctrl     = CTRL_RUN;

    if (mw) begin
      // Inputs are held while waiting, so a coincident redirect replays on release.
      ctrl    = CTRL_MEM_WAIT;
      state_d = HZ_MEM_WAIT;
    end else if (redirect_exmem) begin
      ctrl     = CTRL_REDIRECT;
      lu_cnt_d = '0;
      state_d  = HZ_RUN;
    end else begin
      case (state_q)
        HZ_LU_STALL: begin
          ctrl     = CTRL_LU;
          lu_cnt_d = (lu_cnt_q != '0) ? lu_cnt_q - LU_CNT_W'(1) : '0;
          state_d  = (lu_cnt_d == '0) ? HZ_RUN : HZ_LU_STALL;
        end
        default: begin
          // RUN, release from MEM_WAIT, and the unused encoding all decode as RUN.
          state_d = HZ_RUN;
          if (lu) begin
            ctrl = CTRL_LU;
          end
          if ((state_q == HZ_MEM_WAIT) && (lu_cnt_q != '0)) begin
            state_d = HZ_LU_STALL;
          end else if (lu && (LOAD_USE_BUBBLES > 1)) begin
            lu_cnt_d = LU_CNT_W'(LOAD_USE_BUBBLES - 1);
            state_d  = HZ_LU_STALL;
          end
        end
      endcase
    end

    if (!rst) begin
      ctrl = CTRL_RUN;
    end

    stall_cnt_d = stall_cnt_q;
    if (rst && !ctrl.pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q     <= HZ_RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign ctrl_state  = rst ? 2'(state_q) : 2'(HZ_RUN);
  assign stall_cnt   = stall_cnt_q;

endmodule
